// File: rtl/acc_mul_seq.sv
// Sequential 8x8 multiplier built from four passes through a shared external 4x4 core.
// Latency: 4 cycles from the accept edge to out_valid (fewer with ZERO_SKIP=1); one operation in flight.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready.
//
// Ports: clk/rst_n (async active-low), abort (sync cancel), in_valid/in_ready/a/b/cfg_lvl (operand side),
//        core_a/core_b/core_lvl -> core_prod (shared combinational 4x4 multiplier, same cycle),
//        out_valid/out_ready/prod (result side), busy, op_cnt (consumed results, wrapping).
module acc_mul_seq #(
  parameter bit ZERO_SKIP = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [7:0]       cfg_lvl,
  output logic [3:0]       core_a,
  output logic [3:0]       core_b,
  output logic [1:0]       core_lvl,
  input  logic [7:0]       core_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [2:0] {IDLE, S_LL, S_LH, S_HL, S_HH, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d, lvl_q, lvl_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addend;
  logic [3:0]       need_q;

  // Bit i set means quadrant i (0=LL,1=LH,2=HL,3=HH) must be computed.
  function automatic logic [3:0] quad_need(input logic [7:0] x, input logic [7:0] y);
    logic [3:0] m;
    m = 4'b1111;
    if (ZERO_SKIP) begin
      m[0] = (x[3:0] != 4'h0) && (y[3:0] != 4'h0);
      m[1] = (x[3:0] != 4'h0) && (y[7:4] != 4'h0);
      m[2] = (x[7:4] != 4'h0) && (y[3:0] != 4'h0);
      m[3] = (x[7:4] != 4'h0) && (y[7:4] != 4'h0);
    end
    return m;
  endfunction

  // Lowest pending quadrant in the mask, or DONE when nothing is left.
  function automatic state_t first_quad(input logic [3:0] m);
    if (m[0])      return S_LL;
    else if (m[1]) return S_LH;
    else if (m[2]) return S_HL;
    else if (m[3]) return S_HH;
    else           return DONE;
  endfunction

  assign need_q = quad_need(a_q, b_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    lvl_d    = lvl_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    core_a   = 4'h0;
    core_b   = 4'h0;
    core_lvl = 2'b00;
    addend   = 16'h0000;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          lvl_d   = cfg_lvl;
          acc_d   = 16'h0000;
          state_d = first_quad(quad_need(a, b));
        end
      end
      S_LL: begin
        core_a   = a_q[3:0];
        core_b   = b_q[3:0];
        core_lvl = lvl_q[1:0];
        addend   = {8'h00, core_prod};
        acc_d    = acc_q + addend;
        state_d  = first_quad(need_q & 4'b1110);
      end
      S_LH: begin
        core_a   = a_q[3:0];
        core_b   = b_q[7:4];
        core_lvl = lvl_q[3:2];
        addend   = {4'h0, core_prod, 4'h0};
        acc_d    = acc_q + addend;
        state_d  = first_quad(need_q & 4'b1100);
      end
      S_HL: begin
        core_a   = a_q[7:4];
        core_b   = b_q[3:0];
        core_lvl = lvl_q[5:4];
        addend   = {4'h0, core_prod, 4'h0};
        acc_d    = acc_q + addend;
        state_d  = first_quad(need_q & 4'b1000);
      end
      S_HH: begin
        core_a   = a_q[7:4];
        core_b   = b_q[7:4];
        core_lvl = lvl_q[7:6];
        addend   = {core_prod, 8'h00};
        acc_d    = acc_q + addend;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over both accept and consume: nothing is loaded or counted.
    if (abort) begin
      state_d = IDLE;
      acc_d   = 16'h0000;
      a_d     = a_q;
      b_d     = b_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      lvl_q   <= 8'h00;
      acc_q   <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lvl_q   <= lvl_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign prod      = acc_q;
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_acc_mul_seq.sv
module tb_acc_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        abort, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b, cfg_lvl, core_prod;
  logic [3:0]  core_a, core_b;
  logic [1:0]  core_lvl;
  logic [15:0] prod, op_cnt;

  // ZERO_SKIP=1, CNT_W=4 instance
  logic        z_abort, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
  logic [7:0]  z_a, z_b, z_cfg_lvl, z_core_prod;
  logic [3:0]  z_core_a, z_core_b;
  logic [1:0]  z_core_lvl;
  logic [15:0] z_prod;
  logic [3:0]  z_op_cnt;

  int checks = 0;
  int errors = 0;

  assign core_prod   = core_a * core_b;
  assign z_core_prod = z_core_a * z_core_b;

  acc_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cfg_lvl(cfg_lvl), .core_a(core_a), .core_b(core_b), .core_lvl(core_lvl),
    .core_prod(core_prod), .out_valid(out_valid), .out_ready(out_ready), .prod(prod),
    .busy(busy), .op_cnt(op_cnt)
  );

  acc_mul_seq #(.ZERO_SKIP(1'b1), .CNT_W(4)) dut_z (
    .clk(clk), .rst_n(rst_n), .abort(z_abort), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .a(z_a), .b(z_b), .cfg_lvl(z_cfg_lvl), .core_a(z_core_a), .core_b(z_core_b),
    .core_lvl(z_core_lvl), .core_prod(z_core_prod), .out_valid(z_out_valid),
    .out_ready(z_out_ready), .prod(z_prod), .busy(z_busy), .op_cnt(z_op_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair for one edge; returns 1 ns after the accept edge.
  task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] lv);
    a = av; b = bv; cfg_lvl = lv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic z_accept(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] lv);
    z_a = av; z_b = bv; z_cfg_lvl = lv; z_in_valid = 1'b1;
    step();
    z_in_valid = 1'b0;
  endtask

  // Bounded wait; cyc reaches 20 when out_valid never rises.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
  endtask

  task automatic z_wait_valid(output int cyc);
    cyc = 0;
    while (!z_out_valid && cyc < 20) begin step(); cyc++; end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got %b, want 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({prod, op_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_data: prod=%h op_cnt=%h, want 0", prod, op_cnt);
    end
    checks++;
    if ({core_a, core_b, core_lvl} !== 10'h0) begin
      errors++; $display("FAIL reset_core: got %h, want 0", {core_a, core_b, core_lvl});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_op();
    int cyc;
    out_ready = 1'b1;
    accept(8'hFF, 8'hFF, 8'hE4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (core_lvl !== 2'(i) || core_a !== 4'hF || core_b !== 4'hF) begin
        errors++; $display("FAIL full_core_q%0d: lvl=%0d a=%h b=%h, want lvl=%0d a=f b=f", i, core_lvl, core_a, core_b, i);
      end
      if (i < 3) step();
    end
    step();
    cyc = 4;
    if (!out_valid) begin wait_valid(cyc); cyc += 4; end
    checks++;
    if (cyc !== 4 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_latency: got %0d cycles, want 4", cyc);
    end
    checks++;
    if (prod !== 16'hFE01) begin
      errors++; $display("FAIL full_prod: got %h, want fe01", prod);
    end
    step();
    checks++;
    if (op_cnt !== 16'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL full_consume: op_cnt=%0d in_ready=%b out_valid=%b, want 1 1 0", op_cnt, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    accept(8'h12, 8'h34, 8'h00);
    wait_valid(cyc);
    checks++;
    if (cyc !== 4) begin
      errors++; $display("FAIL bp_latency: got %0d cycles, want 4", cyc);
    end
    // Competing operands while holding must be ignored.
    a = 8'h77; b = 8'h77; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || prod !== 16'h03A8 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: out_valid=%b prod=%h in_ready=%b, want 1 03a8 0", i, out_valid, prod, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_cnt !== 16'd2 || prod !== 16'h03A8) begin
      errors++; $display("FAIL bp_consume: in_ready=%b out_valid=%b op_cnt=%0d prod=%h, want 1 0 2 03a8", in_ready, out_valid, op_cnt, prod);
    end
  endtask

  task automatic test_abort();
    int cyc;
    logic seen;
    accept(8'h55, 8'h66, 8'hE4);
    step();
    checks++;
    if (core_lvl !== 2'd1 || core_b !== 4'h6) begin
      errors++; $display("FAIL abort_in_lh: lvl=%0d b=%h, want 1 6", core_lvl, core_b);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || prod !== 16'h0 || op_cnt !== 16'd2) begin
      errors++; $display("FAIL abort_idle: busy=%b out_valid=%b prod=%h op_cnt=%0d, want 0 0 0 2", busy, out_valid, prod, op_cnt);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= out_valid;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_valid: out_valid rose after abort");
    end
    accept(8'h02, 8'h03, 8'h00);
    wait_valid(cyc);
    checks++;
    if (cyc !== 4 || prod !== 16'h0006) begin
      errors++; $display("FAIL abort_next_op: cycles=%0d prod=%h, want 4 0006", cyc, prod);
    end
    step();
    checks++;
    if (op_cnt !== 16'd3) begin
      errors++; $display("FAIL abort_cnt: got %0d, want 3", op_cnt);
    end
  endtask

  task automatic test_zero_skip();
    int cyc;
    z_out_ready = 1'b0;
    z_accept(8'h30, 8'h05, 8'h20);
    checks++;
    if (z_core_a !== 4'h3 || z_core_b !== 4'h5 || z_core_lvl !== 2'd2) begin
      errors++; $display("FAIL zs_hl_only: a=%h b=%h lvl=%0d, want 3 5 2", z_core_a, z_core_b, z_core_lvl);
    end
    z_wait_valid(cyc);
    checks++;
    if (cyc !== 1 || z_prod !== 16'h00F0) begin
      errors++; $display("FAIL zs_result: cycles=%0d prod=%h, want 1 00f0", cyc, z_prod);
    end
    z_out_ready = 1'b1;
    step();
    z_out_ready = 1'b0;
    z_accept(8'h00, 8'h77, 8'hFF);
    checks++;
    if (z_out_valid !== 1'b1 || z_prod !== 16'h0000) begin
      errors++; $display("FAIL zs_zero: out_valid=%b prod=%h, want 1 0000", z_out_valid, z_prod);
    end
    z_out_ready = 1'b1;
    step();
    checks++;
    if (z_op_cnt !== 4'd2) begin
      errors++; $display("FAIL zs_cnt: got %0d, want 2", z_op_cnt);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    accept(8'hFF, 8'hFF, 8'hE4);
    step();
    step();
    checks++;
    if (core_lvl !== 2'd2 || core_a !== 4'hF) begin
      errors++; $display("FAIL arst_in_hl: lvl=%0d a=%h, want 2 f", core_lvl, core_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || prod !== 16'h0 || op_cnt !== 16'h0 ||
        {core_a, core_b, core_lvl} !== 10'h0 || z_op_cnt !== 4'h0) begin
      errors++; $display("FAIL arst_values: flags=%b prod=%h op_cnt=%h core=%h z_cnt=%h, want 100 0 0 0 0",
                         {in_ready, out_valid, busy}, prod, op_cnt, {core_a, core_b, core_lvl}, z_op_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    accept(8'h02, 8'h03, 8'h00);
    wait_valid(cyc);
    checks++;
    if (cyc !== 4 || prod !== 16'h0006) begin
      errors++; $display("FAIL arst_next_op: cycles=%0d prod=%h, want 4 0006", cyc, prod);
    end
    step();
    checks++;
    if (op_cnt !== 16'd1) begin
      errors++; $display("FAIL arst_cnt: got %0d, want 1", op_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    int cyc;
    z_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      z_accept(8'h11, 8'h11, 8'h00);
      z_wait_valid(cyc);
      if (i == 0) begin
        checks++;
        if (cyc !== 4 || z_prod !== 16'h0121) begin
          errors++; $display("FAIL wrap_op: cycles=%0d prod=%h, want 4 0121", cyc, z_prod);
        end
      end
      step();
      if (i == 14) begin
        checks++;
        if (z_op_cnt !== 4'd15) begin
          errors++; $display("FAIL wrap_15: got %0d, want 15", z_op_cnt);
        end
      end
    end
    checks++;
    if (z_op_cnt !== 4'd0) begin
      errors++; $display("FAIL wrap_0: got %0d, want 0", z_op_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cfg_lvl = '0;
    z_abort = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0; z_a = '0; z_b = '0; z_cfg_lvl = '0;
    test_reset();
    test_full_op();
    test_backpressure();
    test_abort();
    test_zero_skip();
    test_async_reset();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
